// File: rtl/gemm_sched_pkg.sv
// Shared types and helpers for the GEMM tile scheduler: FSM state encoding
// and the last-index compare used by both the scheduler and its tile counter.
package gemm_sched_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_STORE   = 3'd3,
        S_NEXT    = 3'd4,
        S_FINISH  = 3'd5
    } sched_state_t;

    // Callers zero-extend to 32 bits so one helper serves every counter width.
    function automatic logic is_last_idx(input logic [31:0] idx, input logic [31:0] cnt);
        return idx == (cnt - 32'd1);
    endfunction

endpackage

// File: rtl/gemm_tile_counter.sv
// Three-level nested m/n/k tile index counter; k advances fastest and carries
// into n, n carries into m. all_last flags the final (m, n, k) tile.
module gemm_tile_counter
    import gemm_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] cfg_m_tiles,
    input  logic [CNT_W-1:0] cfg_n_tiles,
    input  logic [CNT_W-1:0] cfg_k_tiles,
    output logic [CNT_W-1:0] m_idx,
    output logic [CNT_W-1:0] n_idx,
    output logic [CNT_W-1:0] k_idx,
    output logic             all_last
);

    logic [CNT_W-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
    logic             mLast, nLast, kLast;

    assign mLast = is_last_idx(32'(m_q), 32'(cfg_m_tiles));
    assign nLast = is_last_idx(32'(n_q), 32'(cfg_n_tiles));
    assign kLast = is_last_idx(32'(k_q), 32'(cfg_k_tiles));

    always_comb begin
        m_d = m_q;
        n_d = n_q;
        k_d = k_q;
        if (clear) begin
            m_d = '0;
            n_d = '0;
            k_d = '0;
        end else if (advance) begin
            if (!kLast) begin
                k_d = k_q + CNT_W'(1);
            end else begin
                k_d = '0;
                if (!nLast) begin
                    n_d = n_q + CNT_W'(1);
                end else begin
                    n_d = '0;
                    m_d = mLast ? '0 : m_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
            k_q <= k_d;
        end
    end

    assign m_idx    = m_q;
    assign n_idx    = n_q;
    assign k_idx    = k_q;
    assign all_last = mLast && nLast && kLast;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Handshaked m/n/k tile-loop controller issuing load/compute/store commands.
// Define GEMM_SCHED_PERF_EN to add saturating busy-cycle and stall counters.
module gemm_tile_scheduler
    import gemm_sched_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_m_tiles,
    input  logic [CNT_W-1:0] cfg_n_tiles,
    input  logic [CNT_W-1:0] cfg_k_tiles,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             load_req,
    input  logic             load_ack,
    output logic             comp_req,
    output logic             comp_clear,
    input  logic             comp_ack,
    output logic             store_req,
    input  logic             store_ack,
    output logic [CNT_W-1:0] m_idx,
    output logic [CNT_W-1:0] n_idx,
    output logic [CNT_W-1:0] k_idx
`ifdef GEMM_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
`endif
);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cfgM_q, cfgM_d, cfgN_q, cfgN_d, cfgK_q, cfgK_d;
    logic             err_q, err_d;
    logic [31:0]      wait_q, wait_d;
    logic             cfgValid, kLast, allLast, cntClear, cntAdvance;

    assign cfgValid = (cfg_m_tiles != '0) && (cfg_n_tiles != '0) && (cfg_k_tiles != '0);
    assign kLast    = is_last_idx(32'(k_idx), 32'(cfgK_q));

    gemm_tile_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (cntClear),
        .advance     (cntAdvance),
        .cfg_m_tiles (cfgM_q),
        .cfg_n_tiles (cfgN_q),
        .cfg_k_tiles (cfgK_q),
        .m_idx       (m_idx),
        .n_idx       (n_idx),
        .k_idx       (k_idx),
        .all_last    (allLast)
    );

    always_comb begin
        state_d    = state_q;
        cfgM_d     = cfgM_q;
        cfgN_d     = cfgN_q;
        cfgK_d     = cfgK_q;
        err_d      = err_q;
        wait_d     = (state_q == S_LOAD) ? wait_q : '0;
        cntClear   = 1'b0;
        cntAdvance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!cfgValid) begin
                        err_d = 1'b1;
                    end else begin
                        cfgM_d   = cfg_m_tiles;
                        cfgN_d   = cfg_n_tiles;
                        cfgK_d   = cfg_k_tiles;
                        err_d    = 1'b0;
                        cntClear = 1'b1;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (load_ack) begin
                    state_d = S_COMPUTE;
                end else if (LOAD_TIMEOUT != 0) begin
                    // The stall is only reported; the load keeps waiting.
                    if (wait_q < 32'(LOAD_TIMEOUT)) wait_d = wait_q + 32'd1;
                    if (wait_q == 32'(LOAD_TIMEOUT - 1)) err_d = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (comp_ack) state_d = kLast ? S_STORE : S_NEXT;
            end
            S_STORE: begin
                if (store_ack) state_d = S_NEXT;
            end
            S_NEXT: begin
                cntAdvance = !allLast;
                state_d    = allLast ? S_FINISH : S_LOAD;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cfgM_q  <= '0;
            cfgN_q  <= '0;
            cfgK_q  <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cfgM_q  <= cfgM_d;
            cfgN_q  <= cfgN_d;
            cfgK_q  <= cfgK_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);
    assign err        = err_q;
    assign load_req   = (state_q == S_LOAD);
    assign comp_req   = (state_q == S_COMPUTE);
    assign comp_clear = (state_q == S_COMPUTE) && (k_idx == '0);
    assign store_req  = (state_q == S_STORE);

`ifdef GEMM_SCHED_PERF_EN
    logic [31:0] perfCycles_q, perfStall_q;
    logic        acceptStart, stallCycle;

    assign acceptStart = (state_q == S_IDLE) && start && cfgValid;
    assign stallCycle  = (load_req && !load_ack) || (comp_req && !comp_ack) ||
                         (store_req && !store_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfCycles_q <= '0;
            perfStall_q  <= '0;
        end else if (acceptStart) begin
            perfCycles_q <= '0;
            perfStall_q  <= '0;
        end else begin
            if (busy && (perfCycles_q != '1)) perfCycles_q <= perfCycles_q + 32'd1;
            if (stallCycle && (perfStall_q != '1)) perfStall_q <= perfStall_q + 32'd1;
        end
    end

    assign perf_cycles = perfCycles_q;
    assign perf_stall  = perfStall_q;
`endif

endmodule
